line_buffer_3tap: RTL and testbench
===================================

// Module: line_buffer_3tap
// PURPOSE
//  Streaming 3-row line buffer directly upstream of the 3x3 dilation/erosion stage.
//  Accepts one DATA_W-bit pixel per valid cycle in raster order.
//  Emits three vertically aligned taps: current row, row-1 and row-2.
//  These feed the morphology stage's Line0/Line1/Line2 inputs.
//  Tracks column/row position and flags when a full 3-row window is available.
// PARAMETERS
//  DATA_W   10    pixel width in bits
//  LINE_W   640   pixels per image line (>=4)
//  COL_W    10    column counter width; must satisfy 2**COL_W >= LINE_W
// PORTS
//  CLK      in   1       system clock, rising edge
//  RST_N    in   1       asynchronous active-low reset
//  iDVAL    in   1       input pixel valid; pixel accepted on any cycle with iDVAL=1
//  iSOF     in   1       start of frame; restarts column/row tracking
//  iDATA    in   DATA_W  input pixel
//  oDVAL    out  1       taps valid; asserted 1 cycle after each accepted pixel
//  oTAP0    out  DATA_W  current-row pixel (registered iDATA)
//  oTAP1    out  DATA_W  same column, previous row
//  oTAP2    out  DATA_W  same column, two rows back
//  oPRIMED  out  1       qualifies oDVAL; 1 when oTAP2 holds real data (row index >= 2)
//  oEOL     out  1       with oDVAL, marks the last column of a line
// BEHAVIOUR
//  Reset (async assert, sync deassert)
//   - All outputs are 0; col_cnt=0; row_cnt=0.
//   - RAM contents are not cleared.
//  Storage
//   - Two line RAMs, LINE_W x DATA_W: ram1 holds row-1, ram2 holds row-2.
//  Accepted pixel (iDVAL=1) at address col_cnt, read-before-write:
//   - oTAP0 <= iDATA
//   - oTAP1 <= ram1[col]
//   - oTAP2 <= ram2[col]
//   - ram1[col] <= iDATA; ram2[col] <= old ram1[col]
//   - oDVAL <= 1. Latency is exactly 1 cycle from iDATA to oTAP*.
//  Idle cycle (iDVAL=0)
//   - oDVAL <= 0; taps, oPRIMED, oEOL and counters hold; RAMs are not written.
//  Column counter
//   - Increments per accepted pixel.
//   - At col_cnt==LINE_W-1: oEOL <= 1, col_cnt wraps to 0, row_cnt increments.
//  Row counter
//   - 2 bits, saturates at 2.
//  Priming gate (masks stale RAM data after reset or new frame)
//   - oTAP1 is forced to 0 while row_cnt==0.
//   - oTAP2 is forced to 0 while row_cnt<2.
//   - oPRIMED <= (row_cnt==2) for the accepted pixel.
//  iSOF with iDVAL=1
//   - The pixel is treated as col 0, row 0: the counters use 0 for this pixel,
//     then col_cnt becomes 1 and row_cnt becomes 0.
//   - Taps 1 and 2 output 0.
//  iSOF with iDVAL=0
//   - col_cnt=0 and row_cnt=0 on the next edge; no output change.
//  Short-line error
//   - iSOF mid-line silently truncates the line; no error flag.
//  Reset mid-frame
//   - Next accepted pixel is col 0, row 0; oPRIMED stays 0 for two full lines.
//  Throughput
//   - Back-to-back iDVAL at 1 pixel/cycle is sustained indefinitely; no backpressure.
// STRUCTURE
//  Shared package line_buf_pkg:
//   - localparams DATA_W, LINE_W, COL_W
//   - typedef logic [DATA_W-1:0] pixel_t
//   - typedef logic [COL_W-1:0] col_t
//  Sub-module line_ram:
//   - Single-port synchronous RAM with read-before-write.
//   - Ports: CLK, en, addr, wdata, rdata.
//   - Instantiated twice (ram1, ram2).
//  Top level holds counters, the priming gate and the output registers.
// TESTING
//  1. Reset, then LINE_W=8, 3 lines of pixels value=row*16+col, continuous iDVAL:
//     - row 2 col 3 -> oTAP0=0x23, oTAP1=0x13, oTAP2=0x03, oPRIMED=1.
//  2. Priming: same stream, rows 0-1:
//     - row 0 -> oTAP1=oTAP2=0.
//     - row 1 -> oTAP2=0; oPRIMED=0 throughout.
//  3. Gaps: iDVAL toggled 1/0 every cycle:
//     - oDVAL toggles 1 cycle late; tap values identical to test 1; oEOL only at col 7.
//  4. iSOF at row 2 col 4 (iDVAL=1):
//     - that pixel -> oTAP1=oTAP2=0, oPRIMED=0; next pixel is col 1.
//  5. RST_N pulsed low mid-line 2:
//     - outputs 0 immediately (async).
//     - after release, first 16 pixels -> oPRIMED=0, oTAP2=0.
//  6. LINE_W=8 wrap:
//     - col 7 -> oEOL=1; next pixel col 0 of next row, oEOL=0.
//  Checker: scoreboard compares every oDVAL cycle against a golden 3-row model.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared types and sizing for the 3-row line buffer feeding the
// 3x3 morphology stage.
package line_buf_pkg;
   localparam int DATA_W = 10;
   localparam int LINE_W = 640;
   localparam int COL_W  = 10;

   typedef logic [DATA_W-1:0] pixel_t;
   typedef logic [COL_W-1:0]  col_t;
endpackage

// File: rtl/line_ram.sv
// Single-port line store: synchronous write, read of the old word
// at the same address in the same cycle (read-before-write).
import line_buf_pkg::*;

module line_ram (
   input  logic   CLK,
   input  logic   en,
   input  col_t   addr,
   input  pixel_t wdata,
   output pixel_t rdata
);
   // Covers the full counter range so any column index is in bounds.
   pixel_t mem [2**COL_W];

   assign rdata = mem[addr];

   always_ff @(posedge CLK) begin
      if (en) begin
         mem[addr] <= wdata;
      end
   end
endmodule

// File: rtl/line_buffer_3tap.sv
// Raster-order 3-row line buffer: current row plus the same column
// from the two previous rows, gated until real data is present.
import line_buf_pkg::*;

module line_buffer_3tap #(
   parameter int LINE_LEN = LINE_W
) (
   input  logic   CLK,
   input  logic   RST_N,
   input  logic   iDVAL,
   input  logic   iSOF,
   input  pixel_t iDATA,
   output logic   oDVAL,
   output pixel_t oTAP0,
   output pixel_t oTAP1,
   output pixel_t oTAP2,
   output logic   oPRIMED,
   output logic   oEOL
);
   localparam col_t LAST = col_t'(LINE_LEN - 1);

   col_t       col_q, col_d, col_cur;
   logic [1:0] row_q, row_d, row_cur;
   logic       last;
   pixel_t     rd1, rd2;

   // A start-of-frame pixel is treated as column 0 of row 0.
   always_comb begin
      col_cur = iSOF ? '0 : col_q;
      row_cur = iSOF ? '0 : row_q;
      last    = (col_cur == LAST);
      col_d   = col_cur;
      row_d   = row_cur;
      if (iDVAL) begin
         col_d = last ? '0 : col_cur + col_t'(1);
         if (last && row_cur != 2'd2) begin
            row_d = row_cur + 2'd1;
         end
      end
   end

   line_ram u_ram1 (
      .CLK   (CLK),
      .en    (iDVAL),
      .addr  (col_cur),
      .wdata (iDATA),
      .rdata (rd1)
   );

   line_ram u_ram2 (
      .CLK   (CLK),
      .en    (iDVAL),
      .addr  (col_cur),
      .wdata (rd1),
      .rdata (rd2)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         col_q   <= '0;
         row_q   <= '0;
         oDVAL   <= 1'b0;
         oTAP0   <= '0;
         oTAP1   <= '0;
         oTAP2   <= '0;
         oPRIMED <= 1'b0;
         oEOL    <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         oDVAL <= iDVAL;
         if (iDVAL) begin
            oTAP0   <= iDATA;
            oTAP1   <= (row_cur == 2'd0) ? '0 : rd1;
            oTAP2   <= row_cur[1] ? rd2 : '0;
            oPRIMED <= (row_cur == 2'd2);
            oEOL    <= last;
         end
      end
   end
endmodule

// File: tb/tb_line_buffer_3tap.sv
// Bench for line_buffer_3tap: frame-history model compared every
// cycle, plus literal pins on selected pixels.
module tb_line_buffer_3tap;
   import line_buf_pkg::*;

   localparam int LW = 8;

   logic   CLK = 1'b0;
   logic   RST_N = 1'b1;
   logic   iDVAL = 1'b0;
   logic   iSOF = 1'b0;
   pixel_t iDATA = '0;
   logic   oDVAL, oPRIMED, oEOL;
   pixel_t oTAP0, oTAP1, oTAP2;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   always #5 CLK = ~CLK;

   line_buffer_3tap #(.LINE_LEN(LW)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .iDVAL   (iDVAL),
      .iSOF    (iSOF),
      .iDATA   (iDATA),
      .oDVAL   (oDVAL),
      .oTAP0   (oTAP0),
      .oTAP1   (oTAP1),
      .oTAP2   (oTAP2),
      .oPRIMED (oPRIMED),
      .oEOL    (oEOL)
   );

   // Model: absolute row number in the frame, last three rows kept.
   pixel_t hist [3][LW];
   int     mr, mc;
   logic   e_dv, e_pr, e_eol;
   pixel_t e0, e1, e2;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mr = 0; mc = 0;
         e_dv = 0; e_pr = 0; e_eol = 0;
         e0 = '0; e1 = '0; e2 = '0;
      end else begin
         if (iSOF) begin
            mr = 0; mc = 0;
         end
         e_dv = iDVAL;
         if (iDVAL) begin
            e0    = iDATA;
            e1    = (mr >= 1) ? hist[(mr - 1) % 3][mc] : '0;
            e2    = (mr >= 2) ? hist[(mr - 2) % 3][mc] : '0;
            e_pr  = (mr >= 2);
            e_eol = (mc == LW - 1);
            hist[mr % 3][mc] = iDATA;
            mc++;
            if (mc == LW) begin
               mc = 0;
               mr++;
            end
         end
      end
   end

   always @(negedge CLK) begin
      #1;
      if (armed) begin
         checks++;
         if ({oDVAL, oTAP0, oTAP1, oTAP2, oPRIMED, oEOL} !==
             {e_dv, e0, e1, e2, e_pr, e_eol}) begin
            errors++;
            $display("FAIL cycle t=%0t dut dv=%b t=%h/%h/%h pr=%b eol=%b exp dv=%b t=%h/%h/%h pr=%b eol=%b",
                     $time, oDVAL, oTAP0, oTAP1, oTAP2, oPRIMED, oEOL,
                     e_dv, e0, e1, e2, e_pr, e_eol);
         end
      end
   end

   task automatic lit(input string nm, input logic dv, input pixel_t t0,
                      input pixel_t t1, input pixel_t t2,
                      input logic pr, input logic eol);
      logic [33:0] want;
      want = {dv, t0, t1, t2, pr, eol};
      checks++;
      if ({oDVAL, oTAP0, oTAP1, oTAP2, oPRIMED, oEOL} !== want) begin
         errors++;
         $display("FAIL %s dut=%h want=%h", nm,
                  {oDVAL, oTAP0, oTAP1, oTAP2, oPRIMED, oEOL}, want);
      end
      checks++;
      if ({e_dv, e0, e1, e2, e_pr, e_eol} !== want) begin
         errors++;
         $display("FAIL %s_model got=%h want=%h", nm,
                  {e_dv, e0, e1, e2, e_pr, e_eol}, want);
      end
   endtask

   task automatic pix(input pixel_t d, input logic sof);
      iDVAL = 1'b1;
      iSOF  = sof;
      iDATA = d;
      @(negedge CLK);
      iDVAL = 1'b0;
      iSOF  = 1'b0;
   endtask

   task automatic idle(input logic sof);
      iDVAL = 1'b0;
      iSOF  = sof;
      @(negedge CLK);
      iSOF  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #2 RST_N = 1'b0;
      @(negedge CLK);
      armed = 1'b1;
      lit("reset", 0, 'h0, 'h0, 'h0, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Three continuous lines, value = row*16+col
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < LW; c++) begin
            pix(pixel_t'(r * 16 + c), 1'b0);
            if (r == 0 && c == 2) lit("r0c2", 1, 'h02, 'h0, 'h0, 0, 0);
            if (r == 1 && c == 5) lit("r1c5", 1, 'h15, 'h05, 'h0, 0, 0);
            if (r == 1 && c == 7) lit("r1c7", 1, 'h17, 'h07, 'h0, 0, 1);
            if (r == 2 && c == 3) lit("r2c3", 1, 'h23, 'h13, 'h03, 1, 0);
            if (r == 2 && c == 7) lit("r2c7", 1, 'h27, 'h17, 'h07, 1, 1);
         end
      end

      // Idle start-of-frame, then the same frame with gaps
      idle(1'b1);
      lit("sof_idle_hold", 0, 'h27, 'h17, 'h07, 1, 1);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < LW; c++) begin
            pix(pixel_t'(r * 16 + c), 1'b0);
            if (r == 0 && c == 7) lit("gap_r0c7", 1, 'h07, 'h0, 'h0, 0, 1);
            idle(1'b0);
            if (r == 2 && c == 3) lit("gap_r2c3", 0, 'h23, 'h13, 'h03, 1, 0);
         end
      end

      // Start-of-frame arriving with a pixel at column 4
      for (int c = 0; c < 4; c++) pix(pixel_t'('h30 + c), 1'b0);
      pix('h99, 1'b1);
      lit("sof_pix", 1, 'h99, 'h0, 'h0, 0, 0);
      for (int c = 1; c < LW; c++) begin
         pix(pixel_t'('h40 + c), 1'b0);
         if (c == 7) lit("sof_col7", 1, 'h47, 'h0, 'h0, 0, 1);
      end
      pix('h50, 1'b0);
      lit("wrap_next", 1, 'h50, 'h99, 'h0, 0, 0);

      // Reset in the middle of row 2
      for (int c = 1; c < LW; c++) pix(pixel_t'('h50 + c), 1'b0);
      for (int c = 0; c < 3; c++) pix(pixel_t'('h60 + c), 1'b0);
      RST_N = 1'b0;
      #1;
      lit("async_rst", 0, 'h0, 'h0, 'h0, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 0; k < 16; k++) begin
         pix(pixel_t'('h80 + k), 1'b0);
         if (k == 0) lit("rst_first", 1, 'h80, 'h0, 'h0, 0, 0);
         if (k == 15) lit("rst_k15", 1, 'h8F, 'h87, 'h0, 0, 1);
      end
      for (int c = 0; c < LW; c++) begin
         pix(pixel_t'('hA0 + c), 1'b0);
         if (c == 0) lit("rst_primed", 1, 'hA0, 'h88, 'h80, 1, 0);
      end
      idle(1'b0);
      idle(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
